// File: rtl/usb_in_ep_buffer_pkg.sv
// Shared USB definitions: handshake/data PIDs and the endpoint buffer state encoding.
// Reused by the IN/OUT endpoint buffers and the protocol engine.
package usb_in_ep_buffer_pkg;

  localparam logic [3:0] PidData0 = 4'b0011;
  localparam logic [3:0] PidData1 = 4'b1011;
  localparam logic [3:0] PidNak   = 4'b1010;
  localparam logic [3:0] PidStall = 4'b1110;

  typedef enum logic [1:0] {
    StFill,
    StReady,
    StXmit,
    StWaitAck
  } ep_state_e;

  function automatic logic [3:0] data_pid(input logic toggle);
    return toggle ? PidData1 : PidData0;
  endfunction

endpackage

// File: rtl/usb_ep_pkt_buf.sv
// Single-packet byte storage: one synchronous write port, one asynchronous read port.
module usb_ep_pkt_buf #(
  parameter int unsigned Depth = 32,
  parameter int unsigned AddrW = 5
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [7:0]       wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [7:0]       rdata_o
);

  logic [7:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/usb_in_ep_buffer.sv
// IN endpoint buffer: the function fills one packet, the engine reads it on IN tokens,
// and the packet is held for retransmission until the host ACKs.
module usb_in_ep_buffer
  import usb_in_ep_buffer_pkg::*;
#(
  parameter int unsigned MAX_PKT_SIZE = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_ep_req_i,
  output logic       in_ep_grant_o,
  output logic       in_ep_data_free_o,
  input  logic       in_ep_data_put_i,
  input  logic [7:0] in_ep_data_i,
  input  logic       in_ep_data_done_i,
  input  logic       in_ep_stall_i,
  output logic       in_ep_acked_o,
  input  logic       in_token_i,
  input  logic       setup_token_i,
  input  logic       ack_received_i,
  input  logic       ack_timeout_i,
  output logic       tx_pkt_start_o,
  output logic [3:0] tx_pid_o,
  output logic       tx_data_avail_o,
  output logic [7:0] tx_data_o,
  input  logic       tx_data_get_i
);

  localparam int unsigned AddrW = $clog2(MAX_PKT_SIZE);
  localparam int unsigned CntW  = $clog2(MAX_PKT_SIZE + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_PKT_SIZE);

  ep_state_e       state_q, state_d;
  logic [CntW-1:0] wr_count_q, wr_count_d;
  logic [CntW-1:0] rd_ptr_q, rd_ptr_d;
  logic            toggle_q, toggle_d;
  logic            pkt_start_q, pkt_start_d;
  logic [3:0]      pid_q, pid_d;
  logic            acked_q, acked_d;

  logic wr_en;
  logic rd_en;

  assign in_ep_grant_o     = in_ep_req_i && (state_q == StFill);
  assign in_ep_data_free_o = (state_q == StFill) && (wr_count_q < MaxCnt);
  assign wr_en             = in_ep_data_put_i && in_ep_grant_o && in_ep_data_free_o;
  assign tx_data_avail_o   = (state_q == StXmit) && (rd_ptr_q < wr_count_q);
  assign rd_en             = tx_data_get_i && tx_data_avail_o;
  assign in_ep_acked_o     = acked_q;
  assign tx_pkt_start_o    = pkt_start_q;
  assign tx_pid_o          = pid_q;

  usb_ep_pkt_buf #(
    .Depth (MAX_PKT_SIZE),
    .AddrW (AddrW)
  ) u_pkt_buf (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_count_q[AddrW-1:0]),
    .wdata_i (in_ep_data_i),
    .raddr_i (rd_ptr_q[AddrW-1:0]),
    .rdata_o (tx_data_o)
  );

  always_comb begin
    state_d     = state_q;
    wr_count_d  = wr_count_q;
    rd_ptr_d    = rd_ptr_q;
    toggle_d    = toggle_q;
    pkt_start_d = 1'b0;
    pid_d       = pid_q;
    acked_d     = 1'b0;

    unique case (state_q)
      StFill: begin
        if (wr_en) begin
          wr_count_d = wr_count_q + CntW'(1);
        end
        // A byte written together with done is part of the closing packet.
        if (in_ep_data_done_i || (wr_en && (wr_count_q == MaxCnt - CntW'(1)))) begin
          state_d = StReady;
        end
      end
      StReady: begin
      end
      StXmit: begin
        if (rd_ptr_q == wr_count_q) begin
          state_d = StWaitAck;
        end else if (rd_en) begin
          rd_ptr_d = rd_ptr_q + CntW'(1);
        end
      end
      StWaitAck: begin
        if (ack_received_i) begin
          toggle_d   = ~toggle_q;
          wr_count_d = '0;
          rd_ptr_d   = '0;
          state_d    = StFill;
          acked_d    = 1'b1;
        end else if (ack_timeout_i) begin
          rd_ptr_d = '0;
          state_d  = StReady;
        end
      end
      default: state_d = StFill;
    endcase

    if (in_token_i) begin
      pkt_start_d = 1'b1;
      if (in_ep_stall_i) begin
        pid_d = PidStall;
      end else if (state_q == StFill) begin
        pid_d = PidNak;
      end else begin
        // Also covers an implicit retry from XMIT/WAIT_ACK: rewind and resend.
        pid_d    = data_pid(toggle_q);
        rd_ptr_d = '0;
        state_d  = StXmit;
      end
    end

    if (setup_token_i) begin
      toggle_d   = 1'b1;
      wr_count_d = '0;
      rd_ptr_d   = '0;
      state_d    = StFill;
      acked_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StFill;
      wr_count_q  <= '0;
      rd_ptr_q    <= '0;
      toggle_q    <= 1'b0;
      pkt_start_q <= 1'b0;
      pid_q       <= PidData0;
      acked_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_count_q  <= wr_count_d;
      rd_ptr_q    <= rd_ptr_d;
      toggle_q    <= toggle_d;
      pkt_start_q <= pkt_start_d;
      pid_q       <= pid_d;
      acked_q     <= acked_d;
    end
  end

endmodule

// File: tb/tb_usb_in_ep_buffer.sv
// Bench for usb_in_ep_buffer: directed test-plan sequences plus randomized traffic,
// all checked every cycle against a queue-based packet model.
module tb_usb_in_ep_buffer;

  localparam int Max = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       req, put, done, stall, tok, setup, ackr, tout, get;
  logic [7:0] data;
  logic       grant, free, acked, start, avail;
  logic [3:0] pid;
  logic [7:0] txd;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  usb_in_ep_buffer #(
    .MAX_PKT_SIZE (Max)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .in_ep_req_i       (req),
    .in_ep_grant_o     (grant),
    .in_ep_data_free_o (free),
    .in_ep_data_put_i  (put),
    .in_ep_data_i      (data),
    .in_ep_data_done_i (done),
    .in_ep_stall_i     (stall),
    .in_ep_acked_o     (acked),
    .in_token_i        (tok),
    .setup_token_i     (setup),
    .ack_received_i    (ackr),
    .ack_timeout_i     (tout),
    .tx_pkt_start_o    (start),
    .tx_pid_o          (pid),
    .tx_data_avail_o   (avail),
    .tx_data_o         (txd),
    .tx_data_get_i     (get)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Behavioural model: the packet is a byte queue; phase says who owns it.
  typedef enum {MFill, MReady, MSend, MWait} phase_e;
  phase_e          ph;
  byte unsigned    pkt[$];
  int              rd;
  bit              tog;
  bit              e_start, e_acked;
  logic [3:0]      e_pid;

  initial begin
    phase_e old_ph;
    bit     old_tog;
    forever begin
      @(posedge clk);
      if (reset) begin
        ph = MFill; pkt.delete(); rd = 0; tog = 0;
        e_start = 0; e_acked = 0; e_pid = 4'b0011;
      end else begin
        old_ph  = ph;
        old_tog = tog;
        e_start = 0;
        e_acked = 0;
        if (old_ph == MFill) begin
          if (put && req && pkt.size() < Max) pkt.push_back(data);
          if (done || pkt.size() == Max) ph = MReady;
        end else if (old_ph == MSend) begin
          if (rd == pkt.size()) ph = MWait;
          else if (get) rd++;
        end else if (old_ph == MWait) begin
          if (ackr) begin
            tog = !tog; pkt.delete(); rd = 0; ph = MFill; e_acked = 1;
          end else if (tout) begin
            rd = 0; ph = MReady;
          end
        end
        if (tok) begin
          e_start = 1;
          if (stall) e_pid = 4'b1110;
          else if (old_ph == MFill) e_pid = 4'b1010;
          else begin
            e_pid = old_tog ? 4'b1011 : 4'b0011;
            rd = 0;
            ph = MSend;
          end
        end
        if (setup) begin
          tog = 1; pkt.delete(); rd = 0; ph = MFill; e_acked = 0;
        end
      end
    end
  end

  // Compare process: every cycle out of reset, on the falling edge.
  initial begin
    bit e_avail;
    forever begin
      @(negedge clk);
      if (!reset) begin
        e_avail = (ph == MSend) && (rd < pkt.size());
        chk("grant", grant, req && ph == MFill);
        chk("free", free, ph == MFill && pkt.size() < Max);
        chk("acked", acked, e_acked);
        chk("pkt_start", start, e_start);
        chk("pid", pid, e_pid);
        chk("data_avail", avail, e_avail);
        if (e_avail) chk("tx_data", txd, pkt[rd]);
      end
    end
  end

  byte unsigned q[$];

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic write_q();
    req = 1;
    foreach (q[i]) begin
      put = 1; data = q[i]; step();
    end
    put = 0; req = 0;
  endtask

  task automatic close_pkt();
    req = 1; done = 1; step(); done = 0; req = 0;
  endtask

  task automatic in_tok(input string nm, input logic [3:0] exp_pid);
    tok = 1; step(); tok = 0;
    chk({nm, "_start"}, start, 1);
    chk({nm, "_pid"}, pid, exp_pid);
  endtask

  task automatic read_q(input string nm);
    foreach (q[i]) begin
      chk({nm, "_avail"}, avail, 1);
      chk({nm, "_byte"}, txd, q[i]);
      get = 1; step(); get = 0;
    end
    chk({nm, "_avail_end"}, avail, 0);
    step();
  endtask

  task automatic do_ack(input string nm);
    ackr = 1; step(); ackr = 0;
    chk({nm, "_acked"}, acked, 1);
    chk({nm, "_free"}, free, 1);
    step();
    chk({nm, "_acked_once"}, acked, 0);
  endtask

  initial begin
    {req, put, done, stall, tok, setup, ackr, tout, get} = '0;
    data  = 8'h00;
    reset = 1;
    repeat (3) step();
    chk("rst_grant", grant, 0);
    chk("rst_free", free, 1);
    chk("rst_acked", acked, 0);
    chk("rst_start", start, 0);
    chk("rst_pid", pid, 4'b0011);
    chk("rst_avail", avail, 0);
    reset = 0;
    step();

    // Basic packet, DATA0, then ACK.
    q = {8'h12, 8'h34, 8'h56};
    write_q();
    close_pkt();
    in_tok("t1", 4'b0011);
    read_q("t1");
    do_ack("t1");

    // NAK while filling; the byte survives and goes out later as DATA1.
    q = {8'hA5};
    write_q();
    in_tok("t2_nak", 4'b1010);
    chk("t2_nak_avail", avail, 0);
    close_pkt();
    in_tok("t2", 4'b1011);
    read_q("t2");
    do_ack("t2");

    // Auto-close at MAX_PKT_SIZE bytes.
    q.delete();
    for (int i = 0; i < Max; i++) q.push_back(8'((i * 7 + 3) & 8'hff));
    req = 1;
    foreach (q[i]) begin
      chk("t3_free_before", free, 1);
      put = 1; data = q[i]; step();
    end
    put = 0; req = 0;
    chk("t3_free_full", free, 0);
    in_tok("t3", 4'b0011);
    read_q("t3");
    do_ack("t3");

    // Timeout -> identical retransmission, toggle flips once.
    q = {8'hDE, 8'hAD};
    write_q();
    close_pkt();
    in_tok("t4a", 4'b1011);
    read_q("t4a");
    tout = 1; step(); tout = 0;
    in_tok("t4b", 4'b1011);
    read_q("t4b");
    do_ack("t4");
    close_pkt();
    in_tok("t4z", 4'b0011);
    chk("t4z_avail", avail, 0);
    step();
    do_ack("t4z");

    // STALL leaves the packet intact.
    q = {8'h77};
    write_q();
    close_pkt();
    stall = 1;
    in_tok("t5_stall", 4'b1110);
    chk("t5_stall_avail", avail, 0);
    stall = 0;
    in_tok("t5", 4'b1011);
    read_q("t5");
    do_ack("t5");

    // SETUP forces DATA1 on the next (zero-length) packet.
    setup = 1; step(); setup = 0;
    close_pkt();
    in_tok("t6", 4'b1011);
    chk("t6_avail", avail, 0);
    step();
    do_ack("t6");

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      req   = ($urandom_range(0, 9) < 8);
      put   = $urandom_range(0, 1);
      data  = 8'($urandom);
      done  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 39) == 0) stall = ~stall;
      tok   = ($urandom_range(0, 14) == 0);
      setup = ($urandom_range(0, 149) == 0);
      ackr  = ($urandom_range(0, 7) == 0);
      tout  = ($urandom_range(0, 15) == 0);
      get   = ($urandom_range(0, 9) < 6);
      step();
    end
    {req, put, done, stall, tok, setup, ackr, tout, get} = '0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
